// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared ISA constants, multdiv FSM state encoding and small decode helpers
// for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MD_START = 2'b01,
    ST_MD_WAIT  = 2'b10,
    ST_MD_DONE  = 2'b11
  } md_state_e;

  function automatic logic is_mul(input logic [31:0] ir);
    return (ir[31:27] == OP_RTYPE) && (ir[6:2] == ALU_MUL);
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return (ir[31:27] == OP_RTYPE) && (ir[6:2] == ALU_DIV);
  endfunction

  function automatic logic is_lw(input logic [31:0] ir);
    return ir[31:27] == OP_LW;
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Source-register usage decode of one instruction: which of rs/rt/rd it reads
// as an operand that a preceding load could still be producing.
module hazard_src_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        rs_used,
  output logic [4:0]  rs,
  output logic        rt_used,
  output logic [4:0]  rt,
  output logic        rd_read
);

  logic unused_bits;
  assign unused_bits = &{1'b0, ir[26:22], ir[11:0]};

  assign rs = ir[21:17];
  assign rt = ir[16:12];

  // Store data (sw rd) is covered by bypassing, so only its base register counts.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    rd_read = 1'b0;
    case (ir[31:27])
      OP_RTYPE: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_ADDI, OP_LW, OP_SW: begin
        rs_used = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        rs_used = 1'b1;
        rd_read = 1'b1;
      end
      OP_JR: begin
        rd_read = 1'b1;
      end
      OP_J, OP_JAL, OP_SETX, OP_BEX: begin
        rs_used = 1'b0;
      end
      default: begin
        rs_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken
// control-flow flushes, multdiv sequencing FSM and a saturating stall counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ir_fd,
  input  logic [31:0]      ir_dx,
  input  logic             branch_taken,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic             md_busy,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = $clog2(MD_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  md_state_e        state_r;
  md_state_e        state_next_s;
  logic [TMR_W-1:0] timer_r;
  logic             md_ctrl_mult_r;
  logic             md_ctrl_div_r;
  logic             md_error_r;
  logic [CNT_W-1:0] stall_count_r;

  logic             fd_rs_used_s;
  logic [4:0]       fd_rs_s;
  logic             fd_rt_used_s;
  logic [4:0]       fd_rt_s;
  logic             fd_rd_read_s;
  logic [4:0]       rd_dx_s;
  logic [4:0]       rd_fd_s;
  logic             dx_mul_s;
  logic             dx_div_s;
  logic             load_use_s;
  logic             timeout_s;

  logic             pc_we_s;
  logic             fd_we_s;
  logic             dx_we_s;
  logic             fd_flush_s;
  logic             dx_bubble_s;
  logic             xm_bubble_s;
  logic             md_busy_s;

  logic unused_bits;
  assign unused_bits = &{1'b0, ir_dx[21:7], ir_dx[1:0]};

  hazard_src_decode u_fd_decode (
    .ir      (ir_fd),
    .rs_used (fd_rs_used_s),
    .rs      (fd_rs_s),
    .rt_used (fd_rt_used_s),
    .rt      (fd_rt_s),
    .rd_read (fd_rd_read_s)
  );

  assign rd_dx_s   = ir_dx[26:22];
  assign rd_fd_s   = ir_fd[26:22];
  assign dx_mul_s  = is_mul(ir_dx);
  assign dx_div_s  = is_div(ir_dx);
  assign timeout_s = (timer_r == TMR_LAST);

  // A load into r0 never produces a live value, so it cannot cause a stall.
  assign load_use_s = is_lw(ir_dx) && (rd_dx_s != 5'd0) &&
                      ((fd_rs_used_s && (fd_rs_s == rd_dx_s)) ||
                       (fd_rt_used_s && (fd_rt_s == rd_dx_s)) ||
                       (fd_rd_read_s && (rd_fd_s == rd_dx_s)));

  // Multdiv sequencing: next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dx_mul_s || dx_div_s) begin
          state_next_s = ST_MD_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MD_START: begin
        state_next_s = ST_MD_WAIT;
      end
      ST_MD_WAIT: begin
        if (md_ready || timeout_s) begin
          state_next_s = ST_MD_DONE;
        end else begin
          state_next_s = ST_MD_WAIT;
        end
      end
      ST_MD_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Multdiv sequencing: state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait-cycle timer, cleared on start and advanced while waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_r <= '0;
    end else begin
      case (state_r)
        ST_MD_START: timer_r <= '0;
        ST_MD_WAIT:  timer_r <= timer_r + TMR_ONE;
        default:     timer_r <= timer_r;
      endcase
    end
  end

  // Start strobes are high exactly in MD_START; md_error exactly in MD_DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_ctrl_mult_r <= 1'b0;
      md_ctrl_div_r  <= 1'b0;
      md_error_r     <= 1'b0;
    end else begin
      md_ctrl_mult_r <= (state_r == ST_IDLE) && dx_mul_s;
      md_ctrl_div_r  <= (state_r == ST_IDLE) && dx_div_s && !dx_mul_s;
      md_error_r     <= (state_r == ST_MD_WAIT) &&
                        (md_ready ? md_exception : timeout_s);
    end
  end

  // Pipeline enables and nop injects.
  always_comb begin
    pc_we_s     = 1'b1;
    fd_we_s     = 1'b1;
    dx_we_s     = 1'b1;
    fd_flush_s  = 1'b0;
    dx_bubble_s = 1'b0;
    xm_bubble_s = 1'b0;
    md_busy_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (branch_taken) begin
          fd_flush_s  = 1'b1;
          dx_bubble_s = 1'b1;
        end else if (load_use_s) begin
          pc_we_s     = 1'b0;
          fd_we_s     = 1'b0;
          dx_bubble_s = 1'b1;
        end else begin
          dx_bubble_s = 1'b0;
        end
      end
      ST_MD_START, ST_MD_WAIT: begin
        pc_we_s     = 1'b0;
        fd_we_s     = 1'b0;
        dx_we_s     = 1'b0;
        xm_bubble_s = 1'b1;
        md_busy_s   = 1'b1;
      end
      ST_MD_DONE: begin
        xm_bubble_s = 1'b0;
      end
      default: begin
        xm_bubble_s = 1'b0;
      end
    endcase
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_r <= '0;
    end else if (!pc_we_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign pc_we        = pc_we_s;
  assign fd_we        = fd_we_s;
  assign dx_we        = dx_we_s;
  assign fd_flush     = fd_flush_s;
  assign dx_bubble    = dx_bubble_s;
  assign xm_bubble    = xm_bubble_s;
  assign md_busy      = md_busy_s;
  assign md_ctrl_mult = md_ctrl_mult_r;
  assign md_ctrl_div  = md_ctrl_div_r;
  assign md_error     = md_error_r;
  assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle expected output vectors
// are queued as stimulus is driven and popped when the outputs are sampled.
module tb_hazard_stall_ctrl;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 32;

  localparam logic [4:0] T_R    = 5'b00000;
  localparam logic [4:0] T_J    = 5'b00001;
  localparam logic [4:0] T_BNE  = 5'b00010;
  localparam logic [4:0] T_JAL  = 5'b00011;
  localparam logic [4:0] T_JR   = 5'b00100;
  localparam logic [4:0] T_ADDI = 5'b00101;
  localparam logic [4:0] T_BLT  = 5'b00110;
  localparam logic [4:0] T_SW   = 5'b00111;
  localparam logic [4:0] T_LW   = 5'b01000;
  localparam logic [4:0] T_SETX = 5'b10101;
  localparam logic [4:0] T_BEX  = 5'b10110;
  localparam logic [4:0] A_ADD  = 5'b00000;
  localparam logic [4:0] A_MUL  = 5'b00110;
  localparam logic [4:0] A_DIV  = 5'b00111;

  // {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble, mult, div, busy, error}
  localparam logic [9:0] E_DEF  = 10'b1110000000;
  localparam logic [9:0] E_LU   = 10'b0010100000;
  localparam logic [9:0] E_BR   = 10'b1111100000;
  localparam logic [9:0] E_SMUL = 10'b0000011010;
  localparam logic [9:0] E_SDIV = 10'b0000010110;
  localparam logic [9:0] E_WAIT = 10'b0000010010;
  localparam logic [9:0] E_DOK  = 10'b1110000000;
  localparam logic [9:0] E_DERR = 10'b1110000001;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      ir_fd = 32'd0;
  logic [31:0]      ir_dx = 32'd0;
  logic             branch_taken = 1'b0;
  logic             md_ready = 1'b0;
  logic             md_exception = 1'b0;
  logic             pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble;
  logic             md_ctrl_mult, md_ctrl_div, md_busy, md_error;
  logic [CNT_W-1:0] stall_count;
  logic [9:0]       outs;

  int         tests = 0;
  int         fails = 0;
  int         exp_stall = 0;
  logic [9:0] sb[$];
  logic [9:0] e;

  hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .ir_fd(ir_fd), .ir_dx(ir_dx),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .fd_flush(fd_flush),
    .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div(md_ctrl_div), .md_busy(md_busy), .md_error(md_error),
    .stall_count(stall_count)
  );

  assign outs = {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
                 md_ctrl_mult, md_ctrl_div, md_busy, md_error};

  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {T_R, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd4};
  endfunction

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL reset_outs: got %b want %b", outs, e);
    end
    tests++;
    if (stall_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d want 0", stall_count);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    logic [31:0] fd_tab [0:11];
    logic        st_tab [0:11];
    logic [31:0] lw5;
    int          base;
    lw5 = i_ins(T_LW, 5'd5, 5'd6);
    fd_tab[0]  = r_ins(5'd1, 5'd5, 5'd2, A_ADD);  st_tab[0]  = 1'b1;
    fd_tab[1]  = r_ins(5'd1, 5'd2, 5'd5, A_ADD);  st_tab[1]  = 1'b1;
    fd_tab[2]  = i_ins(T_ADDI, 5'd1, 5'd5);       st_tab[2]  = 1'b1;
    fd_tab[3]  = i_ins(T_SW, 5'd5, 5'd3);         st_tab[3]  = 1'b0;
    fd_tab[4]  = i_ins(T_SW, 5'd3, 5'd5);         st_tab[4]  = 1'b1;
    fd_tab[5]  = i_ins(T_BNE, 5'd5, 5'd3);        st_tab[5]  = 1'b1;
    fd_tab[6]  = i_ins(T_BLT, 5'd3, 5'd5);        st_tab[6]  = 1'b1;
    fd_tab[7]  = i_ins(T_JR, 5'd5, 5'd0);         st_tab[7]  = 1'b1;
    fd_tab[8]  = i_ins(T_J, 5'd5, 5'd5);          st_tab[8]  = 1'b0;
    fd_tab[9]  = i_ins(T_BEX, 5'd5, 5'd5);        st_tab[9]  = 1'b0;
    fd_tab[10] = i_ins(T_SETX, 5'd5, 5'd5);       st_tab[10] = 1'b0;
    fd_tab[11] = r_ins(5'd5, 5'd6, 5'd7, A_ADD);  st_tab[11] = 1'b0;
    base = exp_stall;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      ir_dx = lw5;
      ir_fd = fd_tab[i];
      sb.push_back(st_tab[i] ? E_LU : E_DEF);
      #1;
      e = sb.pop_front();
      tests++;
      if (outs !== e) begin
        fails++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs, e);
      end
      if (!e[9]) exp_stall++;
      if (st_tab[i]) begin
        @(negedge clock);
        ir_dx = 32'd0;
        sb.push_back(E_DEF);
        #1;
        e = sb.pop_front();
        tests++;
        if (outs !== e) begin
          fails++;
          $display("FAIL load_use_release[%0d]: got %b want %b", i, outs, e);
        end
      end
    end
    @(negedge clock);
    ir_dx = i_ins(T_LW, 5'd0, 5'd6);
    ir_fd = r_ins(5'd1, 5'd0, 5'd0, A_ADD);
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL load_r0: got %b want %b", outs, e);
    end
    tests++;
    if (stall_count !== 32'(base + 7)) begin
      fails++;
      $display("FAIL load_use_count: got %0d want %0d", stall_count, base + 7);
    end
    @(negedge clock);
    ir_dx = 32'd0;
    ir_fd = 32'd0;
  endtask

  task automatic test_branch();
    logic [31:0] br_tab [0:2];
    br_tab[0] = i_ins(T_BNE, 5'd1, 5'd2);
    br_tab[1] = i_ins(T_JAL, 5'd0, 5'd0);
    br_tab[2] = i_ins(T_BLT, 5'd4, 5'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ir_dx = br_tab[i];
      ir_fd = r_ins(5'd1, 5'd4, 5'd4, A_ADD);
      branch_taken = 1'b1;
      sb.push_back(E_BR);
      #1;
      e = sb.pop_front();
      tests++;
      if (outs !== e) begin
        fails++;
        $display("FAIL branch[%0d]: got %b want %b", i, outs, e);
      end
    end
    @(negedge clock);
    branch_taken = 1'b0;
    ir_dx = 32'd0;
    ir_fd = 32'd0;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL branch_release: got %b want %b", outs, e);
    end
  endtask

  // ready_at==0 means md_ready never arrives and the timeout must fire.
  task automatic test_multdiv(input logic [31:0] ir, input int ready_at, input logic exc,
                              input logic [9:0] start_exp, input logic [9:0] done_exp);
    int nwait;
    int base;
    nwait = (ready_at == 0) ? MD_TIMEOUT : ready_at;
    base = exp_stall;
    @(negedge clock);
    ir_dx = ir;
    md_ready = 1'b1;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL md_idle: got %b want %b", outs, e);
    end
    @(negedge clock);
    md_ready = 1'b1;
    sb.push_back(start_exp);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL md_start: got %b want %b", outs, e);
    end
    if (!e[9]) exp_stall++;
    for (int k = 1; k <= nwait; k++) begin
      @(negedge clock);
      md_ready = (k == ready_at);
      md_exception = exc && (k == ready_at);
      sb.push_back(E_WAIT);
      #1;
      e = sb.pop_front();
      tests++;
      if (outs !== e) begin
        fails++;
        $display("FAIL md_wait[%0d]: got %b want %b", k, outs, e);
      end
      if (!e[9]) exp_stall++;
    end
    @(negedge clock);
    md_ready = 1'b0;
    md_exception = 1'b0;
    sb.push_back(done_exp);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL md_done: got %b want %b", outs, e);
    end
    @(negedge clock);
    ir_dx = 32'd0;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL md_after: got %b want %b", outs, e);
    end
    tests++;
    if (stall_count !== 32'(base + 1 + nwait)) begin
      fails++;
      $display("FAIL md_count: got %0d want %0d", stall_count, base + 1 + nwait);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq [0:5];
    seq[0] = E_DEF; seq[1] = E_SMUL; seq[2] = E_WAIT;
    seq[3] = E_WAIT; seq[4] = E_WAIT; seq[5] = E_DOK;
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 6; c++) begin
        @(negedge clock);
        ir_dx = r_ins(5'd3, 5'd1, 5'd2, A_MUL);
        md_ready = (c == 4);
        sb.push_back(seq[c]);
        #1;
        e = sb.pop_front();
        tests++;
        if (outs !== e) begin
          fails++;
          $display("FAIL b2b[%0d][%0d]: got %b want %b", rep, c, outs, e);
        end
        if (!e[9]) exp_stall++;
      end
    end
    @(negedge clock);
    ir_dx = 32'd0;
    md_ready = 1'b0;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL b2b_after: got %b want %b", outs, e);
    end
    tests++;
    if (stall_count !== 32'(exp_stall)) begin
      fails++;
      $display("FAIL b2b_count: got %0d want %0d", stall_count, exp_stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [9:0] seq [0:4];
    seq[0] = E_DEF; seq[1] = E_SMUL; seq[2] = E_WAIT; seq[3] = E_WAIT; seq[4] = E_WAIT;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      ir_dx = r_ins(5'd3, 5'd1, 5'd2, A_MUL);
      sb.push_back(seq[c]);
      #1;
      e = sb.pop_front();
      tests++;
      if (outs !== e) begin
        fails++;
        $display("FAIL rst_pre[%0d]: got %b want %b", c, outs, e);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    exp_stall = 0;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL rst_mid_outs: got %b want %b", outs, e);
    end
    tests++;
    if (stall_count !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_count: got %0d want 0", stall_count);
    end
    @(negedge clock);
    reset = 1'b0;
    ir_dx = 32'd0;
    sb.push_back(E_DEF);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL rst_release: got %b want %b", outs, e);
    end
    @(negedge clock);
    ir_dx = i_ins(T_BNE, 5'd2, 5'd3);
    branch_taken = 1'b1;
    sb.push_back(E_BR);
    #1;
    e = sb.pop_front();
    tests++;
    if (outs !== e) begin
      fails++;
      $display("FAIL rst_branch: got %b want %b", outs, e);
    end
    @(negedge clock);
    branch_taken = 1'b0;
    ir_dx = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multdiv(r_ins(5'd3, 5'd1, 5'd2, A_MUL), 32, 1'b0, E_SMUL, E_DOK);
    test_multdiv(r_ins(5'd4, 5'd1, 5'd2, A_DIV), 0, 1'b0, E_SDIV, E_DERR);
    test_multdiv(r_ins(5'd4, 5'd1, 5'd2, A_DIV), 5, 1'b1, E_SDIV, E_DERR);
    test_multdiv(r_ins(5'd3, 5'd1, 5'd2, A_MUL), MD_TIMEOUT, 1'b0, E_SMUL, E_DOK);
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
